// File: rtl/rvvi_trace_gen.sv
// rvvi_trace_gen: producer side of a single-hart, single-retire RVVI trace.
// Commit events are queued in a DEPTH-entry FIFO and presented through a
// registered output stage that the consumer can freeze with rvvi_hold.
//
// Ports
//   clk, reset_n                     clock, synchronous active-low reset
//   cm_valid / cm_ready              commit handshake (push = cm_valid & cm_ready)
//   cm_pc, cm_pc_next, cm_insn       retired PC, next PC, instruction bits
//   cm_trap, cm_intr, cm_halt        trap / interrupt / final-instruction flags
//   cm_mode                          privilege mode at retire
//   cm_rd, cm_rd_we, cm_rd_data      integer writeback
//   rvvi_hold                        consumer stall, freezes the output record
//   rvvi_valid .. rvvi_x_wdata       registered RVVI record
//
// Optional feature macro: RVVI_FREG_TRACE_EN adds FP writeback tracing
// (cm_fd, cm_fd_we, cm_fd_data inputs; rvvi_f_wb, rvvi_f_wdata outputs).
module rvvi_trace_gen #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned FLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cm_valid,
    output logic            cm_ready,
    input  logic [XLEN-1:0] cm_pc,
    input  logic [XLEN-1:0] cm_pc_next,
    input  logic [ILEN-1:0] cm_insn,
    input  logic            cm_trap,
    input  logic            cm_intr,
    input  logic            cm_halt,
    input  logic [1:0]      cm_mode,
    input  logic [4:0]      cm_rd,
    input  logic            cm_rd_we,
    input  logic [XLEN-1:0] cm_rd_data,
`ifdef RVVI_FREG_TRACE_EN
    input  logic [4:0]      cm_fd,
    input  logic            cm_fd_we,
    input  logic [FLEN-1:0] cm_fd_data,
    output logic [31:0]     rvvi_f_wb,
    output logic [FLEN-1:0] rvvi_f_wdata,
`endif
    input  logic            rvvi_hold,
    output logic            rvvi_valid,
    output logic [63:0]     rvvi_order,
    output logic [ILEN-1:0] rvvi_insn,
    output logic [XLEN-1:0] rvvi_pc_rdata,
    output logic [XLEN-1:0] rvvi_pc_wdata,
    output logic            rvvi_trap,
    output logic            rvvi_intr,
    output logic            rvvi_halt,
    output logic [1:0]      rvvi_mode,
    output logic [31:0]     rvvi_x_wb,
    output logic [XLEN-1:0] rvvi_x_wdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // FIFO payload; writeback qualification is resolved at push time
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic            intr;
        logic            halt;
        logic [1:0]      mode;
        logic            x_we;
        logic [4:0]      rd;
        logic [XLEN-1:0] x_data;
`ifdef RVVI_FREG_TRACE_EN
        logic            f_we;
        logic [4:0]      fd;
        logic [FLEN-1:0] f_data;
`endif
    } rec_t;

    rec_t            mem [DEPTH];
    rec_t            wr_rec;
    rec_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_d;
    state_t          state;
    state_t          state_d;
    logic            push;
    logic            pop;

    assign head = mem[rd_ptr];

    // Build the FIFO entry; a trap or a write to x0 suppresses the GPR update
    always_comb begin
        wr_rec         = '0;
        wr_rec.pc      = cm_pc;
        wr_rec.pc_next = cm_pc_next;
        wr_rec.insn    = cm_insn;
        wr_rec.trap    = cm_trap;
        wr_rec.intr    = cm_intr;
        wr_rec.halt    = cm_halt;
        wr_rec.mode    = cm_mode;
        wr_rec.rd      = cm_rd;
        wr_rec.x_we    = cm_rd_we & ~cm_trap & (cm_rd != 5'd0);
        wr_rec.x_data  = wr_rec.x_we ? cm_rd_data : '0;
`ifdef RVVI_FREG_TRACE_EN
        // f0 is a real register, so only a trap suppresses the FP update
        wr_rec.fd      = cm_fd;
        wr_rec.f_we    = cm_fd_we & ~cm_trap;
        wr_rec.f_data  = wr_rec.f_we ? cm_fd_data : '0;
`endif
    end

    // Handshake, occupancy and FSM next state
    always_comb begin
        push    = cm_valid & cm_ready;
        pop     = (~rvvi_valid | ~rvvi_hold) & (count != '0);
        count_d = count;
        state_d = state;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (!push && pop) begin
            count_d = count - CW'(1);
        end
        case (state)
            RUN:     if (push && cm_halt) state_d = DRAIN;
            DRAIN:   if (rvvi_valid && !rvvi_hold && rvvi_halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // State, pointers and the registered ready
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= RUN;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cm_ready <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            cm_ready <= (count_d != CW'(DEPTH)) && (state_d == RUN);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // FIFO storage; contents are don't-care once the pointers reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_rec;
    end

    // Output record; rvvi_order doubles as the emitted-record counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rvvi_valid    <= 1'b0;
            rvvi_order    <= '0;
            rvvi_insn     <= '0;
            rvvi_pc_rdata <= '0;
            rvvi_pc_wdata <= '0;
            rvvi_trap     <= 1'b0;
            rvvi_intr     <= 1'b0;
            rvvi_halt     <= 1'b0;
            rvvi_mode     <= '0;
            rvvi_x_wb     <= '0;
            rvvi_x_wdata  <= '0;
`ifdef RVVI_FREG_TRACE_EN
            rvvi_f_wb     <= '0;
            rvvi_f_wdata  <= '0;
`endif
        end else if (pop) begin
            rvvi_valid    <= 1'b1;
            rvvi_order    <= rvvi_order + 64'd1;
            rvvi_insn     <= head.insn;
            rvvi_pc_rdata <= head.pc;
            rvvi_pc_wdata <= head.pc_next;
            rvvi_trap     <= head.trap;
            rvvi_intr     <= head.intr;
            rvvi_halt     <= head.halt;
            rvvi_mode     <= head.mode;
            rvvi_x_wb     <= head.x_we ? (32'd1 << head.rd) : 32'd0;
            rvvi_x_wdata  <= head.x_data;
`ifdef RVVI_FREG_TRACE_EN
            rvvi_f_wb     <= head.f_we ? (32'd1 << head.fd) : 32'd0;
            rvvi_f_wdata  <= head.f_data;
`endif
        end else if (!rvvi_hold) begin
            rvvi_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvvi_trace_gen.sv
// Directed self-checking bench for rvvi_trace_gen (DEPTH=4, XLEN=64).
module tb_rvvi_trace_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cm_valid = 1'b0;
    logic        cm_ready;
    logic [63:0] cm_pc = '0;
    logic [63:0] cm_pc_next = '0;
    logic [31:0] cm_insn = '0;
    logic        cm_trap = 1'b0;
    logic        cm_intr = 1'b0;
    logic        cm_halt = 1'b0;
    logic [1:0]  cm_mode = 2'd3;
    logic [4:0]  cm_rd = '0;
    logic        cm_rd_we = 1'b0;
    logic [63:0] cm_rd_data = '0;
    logic        rvvi_hold = 1'b0;
    logic        rvvi_valid;
    logic [63:0] rvvi_order;
    logic [31:0] rvvi_insn;
    logic [63:0] rvvi_pc_rdata;
    logic [63:0] rvvi_pc_wdata;
    logic        rvvi_trap;
    logic        rvvi_intr;
    logic        rvvi_halt;
    logic [1:0]  rvvi_mode;
    logic [31:0] rvvi_x_wb;
    logic [63:0] rvvi_x_wdata;
`ifdef RVVI_FREG_TRACE_EN
    logic [4:0]  cm_fd = '0;
    logic        cm_fd_we = 1'b0;
    logic [63:0] cm_fd_data = '0;
    logic [31:0] rvvi_f_wb;
    logic [63:0] rvvi_f_wdata;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvvi_trace_gen #(.XLEN(64), .ILEN(32), .FLEN(64), .DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cm_valid      (cm_valid),
        .cm_ready      (cm_ready),
        .cm_pc         (cm_pc),
        .cm_pc_next    (cm_pc_next),
        .cm_insn       (cm_insn),
        .cm_trap       (cm_trap),
        .cm_intr       (cm_intr),
        .cm_halt       (cm_halt),
        .cm_mode       (cm_mode),
        .cm_rd         (cm_rd),
        .cm_rd_we      (cm_rd_we),
        .cm_rd_data    (cm_rd_data),
`ifdef RVVI_FREG_TRACE_EN
        .cm_fd         (cm_fd),
        .cm_fd_we      (cm_fd_we),
        .cm_fd_data    (cm_fd_data),
        .rvvi_f_wb     (rvvi_f_wb),
        .rvvi_f_wdata  (rvvi_f_wdata),
`endif
        .rvvi_hold     (rvvi_hold),
        .rvvi_valid    (rvvi_valid),
        .rvvi_order    (rvvi_order),
        .rvvi_insn     (rvvi_insn),
        .rvvi_pc_rdata (rvvi_pc_rdata),
        .rvvi_pc_wdata (rvvi_pc_wdata),
        .rvvi_trap     (rvvi_trap),
        .rvvi_intr     (rvvi_intr),
        .rvvi_halt     (rvvi_halt),
        .rvvi_mode     (rvvi_mode),
        .rvvi_x_wb     (rvvi_x_wb),
        .rvvi_x_wdata  (rvvi_x_wdata)
    );

    // Advance one cycle; inputs change and outputs are sampled 1ns after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cm_valid  = 1'b0;
        cm_halt   = 1'b0;
        cm_trap   = 1'b0;
        rvvi_hold = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Present one commit event for one cycle (caller ensures cm_ready=1)
    task automatic push_rec(input logic [63:0] pc, input logic [31:0] insn,
                            input logic [4:0] rd, input logic we,
                            input logic [63:0] data, input logic trap);
        cm_pc      = pc;
        cm_pc_next = pc + 64'd4;
        cm_insn    = insn;
        cm_rd      = rd;
        cm_rd_we   = we;
        cm_rd_data = data;
        cm_trap    = trap;
        cm_valid   = 1'b1;
        tick();
        cm_valid   = 1'b0;
        cm_trap    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (rvvi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h exp 0", rvvi_valid); end
        checks++; if (rvvi_order !== 64'd0) begin errors++; $display("FAIL reset_order: got %0h exp 0", rvvi_order); end
        checks++; if (rvvi_x_wb !== 32'd0) begin errors++; $display("FAIL reset_x_wb: got %0h exp 0", rvvi_x_wb); end
        checks++; if (cm_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %0h exp 0", cm_ready); end
        reset_n = 1'b1;
        tick();
        checks++; if (cm_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %0h exp 1", cm_ready); end
    endtask

    task automatic test_basic();
        push_rec(64'h8000_0000, 32'h0050_0293, 5'd5, 1'b1, 64'd5, 1'b0);
        checks++; if (rvvi_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got %0h exp 0", rvvi_valid); end
        tick();
        checks++; if (rvvi_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h exp 1", rvvi_valid); end
        checks++; if (rvvi_order !== 64'd1) begin errors++; $display("FAIL basic_order: got %0h exp 1", rvvi_order); end
        checks++; if (rvvi_x_wb !== 32'h0000_0020) begin errors++; $display("FAIL basic_x_wb: got %0h exp 20", rvvi_x_wb); end
        checks++; if (rvvi_x_wdata !== 64'd5) begin errors++; $display("FAIL basic_x_wdata: got %0h exp 5", rvvi_x_wdata); end
        checks++; if (rvvi_pc_wdata !== 64'h8000_0004) begin errors++; $display("FAIL basic_pc_wdata: got %0h exp 80000004", rvvi_pc_wdata); end
        checks++; if (rvvi_pc_rdata !== 64'h8000_0000) begin errors++; $display("FAIL basic_pc_rdata: got %0h exp 80000000", rvvi_pc_rdata); end
        checks++; if (rvvi_insn !== 32'h0050_0293) begin errors++; $display("FAIL basic_insn: got %0h exp 00500293", rvvi_insn); end
        checks++; if (rvvi_mode !== 2'd3) begin errors++; $display("FAIL basic_mode: got %0h exp 3", rvvi_mode); end
        tick();
        checks++; if (rvvi_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %0h exp 0", rvvi_valid); end
    endtask

    task automatic test_x0_write();
        push_rec(64'h8000_0004, 32'h0000_0013, 5'd0, 1'b1, 64'hdead, 1'b0);
        tick();
        checks++; if (rvvi_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %0h exp 1", rvvi_valid); end
        checks++; if (rvvi_order !== 64'd2) begin errors++; $display("FAIL x0_order: got %0h exp 2", rvvi_order); end
        checks++; if (rvvi_x_wb !== 32'd0) begin errors++; $display("FAIL x0_x_wb: got %0h exp 0", rvvi_x_wb); end
        checks++; if (rvvi_x_wdata !== 64'd0) begin errors++; $display("FAIL x0_x_wdata: got %0h exp 0", rvvi_x_wdata); end
        tick();
    endtask

    task automatic test_trap();
        push_rec(64'h8000_0008, 32'h0000_0073, 5'd7, 1'b1, 64'h77, 1'b1);
        tick();
        checks++; if (rvvi_order !== 64'd3) begin errors++; $display("FAIL trap_order: got %0h exp 3", rvvi_order); end
        checks++; if (rvvi_trap !== 1'b1) begin errors++; $display("FAIL trap_flag: got %0h exp 1", rvvi_trap); end
        checks++; if (rvvi_x_wb !== 32'd0) begin errors++; $display("FAIL trap_x_wb: got %0h exp 0", rvvi_x_wb); end
        tick();
        push_rec(64'h8000_0100, 32'h0090_0093, 5'd1, 1'b1, 64'd9, 1'b0);
        tick();
        checks++; if (rvvi_order !== 64'd4) begin errors++; $display("FAIL post_trap_order: got %0h exp 4", rvvi_order); end
        checks++; if (rvvi_trap !== 1'b0) begin errors++; $display("FAIL post_trap_flag: got %0h exp 0", rvvi_trap); end
        checks++; if (rvvi_x_wb !== 32'h0000_0002) begin errors++; $display("FAIL post_trap_x_wb: got %0h exp 2", rvvi_x_wb); end
        checks++; if (rvvi_x_wdata !== 64'd9) begin errors++; $display("FAIL post_trap_x_wdata: got %0h exp 9", rvvi_x_wdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        do_reset();
        rvvi_hold = 1'b1;
        cm_rd = 5'd3; cm_rd_we = 1'b1; cm_trap = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cm_valid   = 1'b1;
            cm_pc      = 64'h1000 + 64'(4 * acc);
            cm_pc_next = cm_pc + 64'd4;
            cm_rd_data = 64'(acc + 100);
            if (cm_ready === 1'b1) acc++;
            tick();
        end
        cm_valid = 1'b0;
        checks++; if (acc !== 5) begin errors++; $display("FAIL b2b_accepted: got %0d exp 5", acc); end
        checks++; if (cm_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0h exp 0", cm_ready); end
        checks++; if (rvvi_valid !== 1'b1 || rvvi_order !== 64'd1) begin errors++; $display("FAIL b2b_held: got valid=%0h order=%0h exp 1/1", rvvi_valid, rvvi_order); end
        rvvi_hold = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (rvvi_valid !== 1'b1 || rvvi_order !== 64'(k) ||
                rvvi_pc_rdata !== 64'h1000 + 64'(4 * (k - 1)) || rvvi_x_wdata !== 64'(k + 99)) begin
                errors++;
                $display("FAIL b2b_drain_%0d: got valid=%0h order=%0h pc=%0h data=%0h exp 1/%0h/%0h/%0h",
                         k, rvvi_valid, rvvi_order, rvvi_pc_rdata, rvvi_x_wdata,
                         k, 64'h1000 + 64'(4 * (k - 1)), k + 99);
            end
            tick();
        end
        checks++; if (rvvi_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0h exp 0", rvvi_valid); end
        checks++; if (cm_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %0h exp 1", cm_ready); end
    endtask

    task automatic test_halt();
        int acc = 0;
        int nrec = 0;
        int nhalt = 0;
        logic [63:0] halt_order = '0;
        do_reset();
        cm_rd = 5'd4; cm_rd_we = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cm_valid   = 1'b1;
            cm_halt    = (acc == 2);
            cm_pc      = 64'h2000 + 64'(4 * acc);
            cm_pc_next = cm_pc + 64'd4;
            if (rvvi_valid === 1'b1) begin
                nrec++;
                if (rvvi_halt === 1'b1) begin
                    nhalt++;
                    halt_order = rvvi_order;
                end
            end
            if (cm_ready === 1'b1) acc++;
            tick();
        end
        cm_valid = 1'b0;
        cm_halt  = 1'b0;
        checks++; if (acc !== 3) begin errors++; $display("FAIL halt_accepted: got %0d exp 3", acc); end
        checks++; if (nrec !== 3) begin errors++; $display("FAIL halt_records: got %0d exp 3", nrec); end
        checks++; if (nhalt !== 1) begin errors++; $display("FAIL halt_count: got %0d exp 1", nhalt); end
        checks++; if (halt_order !== 64'd3) begin errors++; $display("FAIL halt_order: got %0h exp 3", halt_order); end
        checks++; if (cm_ready !== 1'b0) begin errors++; $display("FAIL halted_ready: got %0h exp 0", cm_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rvvi_hold = 1'b1;
        cm_rd = 5'd6; cm_rd_we = 1'b1;
        for (int i = 0; i < 3; i++) push_rec(64'h3000 + 64'(4 * i), 32'h13, 5'd6, 1'b1, 64'(i + 1), 1'b0);
        checks++; if (rvvi_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0h exp 1", rvvi_valid); end
        reset_n = 1'b0;
        tick();
        checks++;
        if (rvvi_valid !== 1'b0 || rvvi_order !== 64'd0 || rvvi_pc_rdata !== 64'd0 ||
            rvvi_insn !== 32'd0 || rvvi_x_wb !== 32'd0 || rvvi_x_wdata !== 64'd0 || cm_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got valid=%0h order=%0h pc=%0h insn=%0h x_wb=%0h ready=%0h exp all 0",
                     rvvi_valid, rvvi_order, rvvi_pc_rdata, rvvi_insn, rvvi_x_wb, cm_ready);
        end
        reset_n   = 1'b1;
        rvvi_hold = 1'b0;
        tick();
        push_rec(64'h4000, 32'h0010_0113, 5'd2, 1'b1, 64'h42, 1'b0);
        tick();
        checks++; if (rvvi_valid !== 1'b1 || rvvi_order !== 64'd1) begin errors++; $display("FAIL mid_first_order: got valid=%0h order=%0h exp 1/1", rvvi_valid, rvvi_order); end
        checks++; if (rvvi_pc_rdata !== 64'h4000) begin errors++; $display("FAIL mid_first_pc: got %0h exp 4000", rvvi_pc_rdata); end
        tick();
        checks++; if (rvvi_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %0h exp 0", rvvi_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0_write();
        test_trap();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
